// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between N requesters and the arbiter.
// The master side drives requests; the slave side (arbiter) drives grants.
interface priority_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  req;
    logic          rr_mode;
    logic          done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          timeout;

    modport master (
        output req, rr_mode, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, rr_mode, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/priority_arbiter.sv
// Registered N-channel arbiter: fixed-priority (highest index) or round-robin,
// holding each grant until done, request drop, or the MAX_HOLD limit.
module priority_arbiter #(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    priority_arbiter_if.slave  bus
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    state_t        state_reg, state_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic          timeout_reg, timeout_next;

    logic [IW-1:0] rot_idx [N];
    logic [N-1:0]  rot_req;
    logic [N-1:0]  win_onehot;
    logic [IW-1:0] fix_win, rr_win, win_idx;
    logic          owner_req, hold_hit, release_now;

    // rot_idx[gi] is the channel examined at scan offset gi from ptr.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum          = {1'b0, ptr_reg} + (IW+1)'(gi);
            assign rot_idx[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            assign rot_req[gi]  = bus.req[rot_idx[gi]];
            assign win_onehot[gi] = (win_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        fix_win = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) fix_win = IW'(i);
        end
        // Descending scan so the smallest offset from ptr is the last write.
        rr_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) rr_win = rot_idx[i];
        end
        win_idx = bus.rr_mode ? rr_win : fix_win;
    end

    assign owner_req   = bus.req[idx_reg];
    assign hold_hit    = HOLD_EN && (cnt_reg == HOLD_LAST);
    assign release_now = bus.done || !owner_req || hold_hit;

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        idx_next     = idx_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (|bus.req) begin
                    state_next = S_GRANT;
                    gnt_next   = win_onehot;
                    idx_next   = win_idx;
                    cnt_next   = '0;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    state_next   = S_IDLE;
                    gnt_next     = '0;
                    idx_next     = '0;
                    cnt_next     = '0;
                    ptr_next     = (idx_reg == IW'(N - 1)) ? '0 : idx_reg + IW'(1);
                    // Only a pure hold-limit revoke counts as a timeout.
                    timeout_next = hold_hit && !bus.done && owner_req;
                end else if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            gnt_reg     <= '0;
            idx_reg     <= '0;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            idx_reg     <= idx_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_idx   = idx_reg;
    assign bus.gnt_valid = (state_reg == S_GRANT);
    assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed, table-driven bench for priority_arbiter (N=4, MAX_HOLD=8),
// plus hand-written hold-limit and mid-grant reset sequences.
module tb_priority_arbiter;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    priority_arbiter_if #(.N(4), .IW(2)) bus ();

    priority_arbiter #(.N(4), .IW(2), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rr;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic m, input logic d,
                                input logic [3:0] g, input logic [1:0] i, input logic v, input logic t);
        vec_t x;
        x.rst_n = r; x.req = q; x.rr = m; x.done = d;
        x.gnt = g; x.idx = i; x.valid = v; x.tmo = t;
        return x;
    endfunction

    // Inputs are applied away from the edge; outputs sampled 1 time unit after it.
    task automatic drive(input logic r, input logic [3:0] q, input logic m, input logic d);
        reset_n     = r;
        bus.req     = q;
        bus.rr_mode = m;
        bus.done    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic t);
        checks++;
        if (bus.gnt !== g || bus.gnt_idx !== i || bus.gnt_valid !== v || bus.timeout !== t) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
                     name, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, g, i, v, t);
        end else begin
            $display("ok   %s: gnt=%b idx=%0d valid=%b timeout=%b",
                     name, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        bus.req     = '0;
        bus.rr_mode = 1'b0;
        bus.done    = 1'b0;

        //                rst req     rr done   gnt     idx   v  tmo
        // reset held two edges with all requests up, then idle
        vecs.push_back(mk(0, 4'b1111, 0, 0,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 0,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 2'd0, 0, 0));
        // fixed priority: channel 2 every time, one idle cycle between grants
        vecs.push_back(mk(1, 4'b0111, 0, 0,   4'b0100, 2'd2, 1, 0));
        vecs.push_back(mk(1, 4'b0111, 0, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b0111, 0, 0,   4'b0100, 2'd2, 1, 0));
        vecs.push_back(mk(1, 4'b0111, 0, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b0111, 0, 0,   4'b0100, 2'd2, 1, 0));
        vecs.push_back(mk(1, 4'b0111, 0, 1,   4'b0000, 2'd0, 0, 0));
        // reset to bring ptr back to 0, then round-robin 0,1,2,3,0
        vecs.push_back(mk(0, 4'b0000, 1, 0,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 0,   4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 0,   4'b0010, 2'd1, 1, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 0,   4'b0100, 2'd2, 1, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 0,   4'b1000, 2'd3, 1, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 0,   4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 1,   4'b0000, 2'd0, 0, 0));
        // request drop on channel 1 (ptr=1), next round-robin grant to 2
        vecs.push_back(mk(1, 4'b0110, 1, 0,   4'b0010, 2'd1, 1, 0));
        vecs.push_back(mk(1, 4'b0100, 1, 0,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 1, 0,   4'b0100, 2'd2, 1, 0));
        vecs.push_back(mk(1, 4'b0100, 1, 1,   4'b0000, 2'd0, 0, 0));
        // ptr=3, req 0011: round-robin wraps to 0 (fixed would pick 1);
        // mode/non-owner changes mid-grant are ignored until next arbitration
        vecs.push_back(mk(1, 4'b0011, 1, 0,   4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(1, 4'b1011, 0, 0,   4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(1, 4'b1011, 0, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b1011, 0, 0,   4'b1000, 2'd3, 1, 0));
        vecs.push_back(mk(1, 4'b1011, 0, 1,   4'b0000, 2'd0, 0, 0));
        // done while idle is ignored, including on the grant-loading edge
        vecs.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 1,   4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 1,   4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 0,   4'b0001, 2'd0, 1, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 2'd0, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst_n, vecs[k].req, vecs[k].rr, vecs[k].done);
            check($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].valid, vecs[k].tmo);
        end

        // Hold limit: exactly 8 cycles of gnt_valid, timeout pulse, regrant after one idle cycle.
        drive(1, 4'b0001, 0, 0);
        check("hold_c1", 4'b0001, 2'd0, 1, 0);
        for (int c = 2; c <= 8; c++) begin
            drive(1, 4'b0001, 0, 0);
            check($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1, 0);
        end
        drive(1, 4'b0001, 0, 0);
        check("hold_revoke", 4'b0000, 2'd0, 0, 1);
        drive(1, 4'b0001, 0, 0);
        check("hold_regrant", 4'b0001, 2'd0, 1, 0);
        for (int c = 2; c <= 8; c++) begin
            drive(1, 4'b0001, 0, 0);
            check($sformatf("hold2_c%0d", c), 4'b0001, 2'd0, 1, 0);
        end
        // done coincides with the limit: normal release, no timeout
        drive(1, 4'b0001, 0, 1);
        check("hold_done_at_limit", 4'b0000, 2'd0, 0, 0);
        drive(1, 4'b0000, 0, 0);
        check("hold_idle", 4'b0000, 2'd0, 0, 0);

        // Mid-grant reset with counter = 3; ptr was 1 before reset.
        drive(1, 4'b0001, 1, 0);
        check("mid_load", 4'b0001, 2'd0, 1, 0);
        for (int c = 1; c <= 3; c++) begin
            drive(1, 4'b0001, 1, 0);
            check($sformatf("mid_hold%0d", c), 4'b0001, 2'd0, 1, 0);
        end
        drive(0, 4'b0001, 1, 0);
        check("mid_reset", 4'b0000, 2'd0, 0, 0);
        // With ptr reset to 0, req 1001 goes to 0; a stale ptr of 1 would pick 3.
        drive(1, 4'b1001, 1, 0);
        check("post_reset_rr", 4'b0001, 2'd0, 1, 0);
        drive(1, 4'b1001, 1, 1);
        check("post_reset_rel", 4'b0000, 2'd0, 0, 0);
        drive(1, 4'b1000, 1, 0);
        check("post_reset_ch3", 4'b1000, 2'd3, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
